// File: rtl/nor_logic_pkg.sv
// Shared definitions for the NOR logic unit: function-select codes and default width.
package nor_logic_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NOR   = 3'd0,
        OP_NOTA  = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_NAND  = 3'd4,
        OP_XOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

endpackage

// File: rtl/nor_vec.sv
// Bitwise 2-input NOR over WIDTH bits; the only logic primitive of the datapath.
module nor_vec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = ~(a | b);

endmodule

// File: rtl/nor_logic_unit.sv
// Two-stage pipelined bitwise logic unit built from NOR terms, with an optional
// accumulator that can replace operand A. Valid/ready: a beat moves when valid && ready.
module nor_logic_unit
    import nor_logic_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ACC_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero
);

    logic             acc_mode_eff;
    logic             acc_clr_eff;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] opa;

    logic             s1_valid;
    logic             s1_acc;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_nab;
    logic [WIDTH-1:0] s1_naa;
    logic [WIDTH-1:0] s1_nbb;
    logic             out_acc;

    logic             in_fire;
    logic             out_fire;
    logic             s2_load;
    logic             s1_free;
    logic             acc_lock;
    logic             in_flight;

    logic [WIDTH-1:0] nab;
    logic [WIDTH-1:0] naa;
    logic [WIDTH-1:0] nbb;
    logic [WIDTH-1:0] and_t;
    logic [WIDTH-1:0] or_t;
    logic [WIDTH-1:0] nand_t;
    logic [WIDTH-1:0] xor_t;
    logic [WIDTH-1:0] xnor_t;
    logic [WIDTH-1:0] pass_t;
    logic [WIDTH-1:0] res;

    assign acc_mode_eff = (ACC_EN != 0) ? acc_mode : 1'b0;
    assign acc_clr_eff  = (ACC_EN != 0) ? acc_clr  : 1'b0;
    assign opa          = acc_mode_eff ? acc_q : a;

    assign out_fire  = out_valid && out_ready;
    assign s2_load   = s1_valid && (!out_valid || out_ready);
    assign s1_free   = !s1_valid || s2_load;
    assign in_flight = s1_valid || out_valid;
    // An accumulate beat must see the accumulator after every older beat has retired,
    // and nothing may follow it until its own result has been handed off.
    assign acc_lock  = (s1_valid && s1_acc) || (out_valid && out_acc);
    assign in_ready  = rst_n && s1_free && !acc_lock && !(acc_mode_eff && in_flight);
    assign in_fire   = in_valid && in_ready;

    nor_vec #(.WIDTH(WIDTH)) u_nab (.a(opa), .b(b),   .y(nab));
    nor_vec #(.WIDTH(WIDTH)) u_naa (.a(opa), .b(opa), .y(naa));
    nor_vec #(.WIDTH(WIDTH)) u_nbb (.a(b),   .b(b),   .y(nbb));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_acc   <= 1'b0;
            s1_op    <= OP_NOR;
            s1_nab   <= '0;
            s1_naa   <= '0;
            s1_nbb   <= '0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_load);
            if (in_fire) begin
                s1_acc <= acc_mode_eff;
                s1_op  <= op_e'(op);
                s1_nab <= nab;
                s1_naa <= naa;
                s1_nbb <= nbb;
            end
        end
    end

    // Level 2: every function is one or two further NORs of the registered terms.
    nor_vec #(.WIDTH(WIDTH)) u_and  (.a(s1_naa), .b(s1_nbb), .y(and_t));
    nor_vec #(.WIDTH(WIDTH)) u_or   (.a(s1_nab), .b(s1_nab), .y(or_t));
    nor_vec #(.WIDTH(WIDTH)) u_nand (.a(and_t),  .b(and_t),  .y(nand_t));
    nor_vec #(.WIDTH(WIDTH)) u_xor  (.a(s1_nab), .b(and_t),  .y(xor_t));
    nor_vec #(.WIDTH(WIDTH)) u_xnor (.a(xor_t),  .b(xor_t),  .y(xnor_t));
    nor_vec #(.WIDTH(WIDTH)) u_pass (.a(s1_naa), .b(s1_naa), .y(pass_t));

    always_comb begin
        res = s1_nab;
        case (s1_op)
            OP_NOR:   res = s1_nab;
            OP_NOTA:  res = s1_naa;
            OP_AND:   res = and_t;
            OP_OR:    res = or_t;
            OP_NAND:  res = nand_t;
            OP_XOR:   res = xor_t;
            OP_XNOR:  res = xnor_t;
            OP_PASSA: res = pass_t;
            default:  res = s1_nab;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_acc   <= 1'b0;
            y         <= '0;
        end else begin
            out_valid <= s2_load || (out_valid && !out_ready);
            if (s2_load) begin
                y       <= res;
                out_acc <= s1_acc;
            end
        end
    end

    // Clear has priority over loading the handed-off result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr_eff) begin
            acc_q <= '0;
        end else if (out_fire) begin
            acc_q <= y;
        end
    end

    assign y_zero = ~|y;

endmodule

// File: doc/nor_logic_unit.md
NOR_LOGIC_UNIT -- requirements
Module: nor_logic_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 1..64.
REQ-002 Parameter ACC_EN, default 1, includes the accumulate feature; when 0, acc_mode and acc_clr are ignored.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  unit accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  function select, sampled with the beat.
REQ-010 acc_mode  input  1  replaces A with the accumulator, sampled with the beat.
REQ-011 acc_clr  input  1  synchronous accumulator clear.
REQ-012 out_valid  output  1  result beat presented.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 y  output  WIDTH  result.
REQ-015 y_zero  output  1  high when y == 0, qualified by out_valid.

Function
REQ-016 Op encoding SHALL be: 0 NOR, 1 NOT A, 2 AND, 3 OR, 4 NAND, 5 XOR, 6 XNOR, 7 PASS A; all functions are bitwise over WIDTH bits.
REQ-017 Every function SHALL be built only from 2-input bitwise NOR; no other logic operator is used in the datapath.
REQ-018 The input handshake fires when in_valid && in_ready; the output handshake fires when out_valid && out_ready.
REQ-019 Stage 1 SHALL register the level-1 NOR terms ~(A|B), ~(A|A), ~(B|B) and op.
REQ-020 Stage 2 SHALL register the final result into y.
REQ-021 Latency: an input handshake in cycle N SHALL produce out_valid in cycle N+2 when there is no stall.
REQ-022 Throughput SHALL be one beat per cycle when acc_mode = 0 and out_ready is held high.
REQ-023 Backpressure: a stage advances only when its downstream stage is empty or is draining in the same cycle.
REQ-024 in_ready SHALL be 1 when stage 1 can advance; it is combinational from out_ready and the stage valids.
REQ-025 While out_valid && !out_ready, y, y_zero and out_valid SHALL hold stable.
REQ-026 No beat is dropped or duplicated.
REQ-027 Accumulator: a WIDTH-bit register that loads y on every output handshake.
REQ-028 An acc_mode beat SHALL use the accumulator value as A.
REQ-029 Hazard rule: in_ready SHALL be 0 for an acc_mode beat while any beat is in flight, and an acc_mode beat blocks acceptance of subsequent beats until it completes its output handshake.
REQ-030 If acc_clr coincides with an output handshake, the clear wins and the accumulator becomes 0.
REQ-031 An acc_clr while an acc_mode beat is in flight does not alter that beat's already-sampled A.
REQ-032 An illegal state cannot exist: all 8 op codes are defined.

Reset
REQ-033 rst_n low SHALL asynchronously clear both stage valids, out_valid, y, the accumulator and the stage-1 registers to 0; y_zero then reads 1.
REQ-034 During reset, in_ready SHALL be 0.
REQ-035 After rst_n rises, in_ready SHALL be 1 from the first clock edge.
REQ-036 Reset asserted mid-operation discards all in-flight beats without producing an output handshake.

Structure
REQ-037 A shared package nor_logic_pkg SHALL hold the op code constants and the default WIDTH.
REQ-038 One sub-module, nor_vec (parametrised WIDTH, y = ~(a|b)), SHALL be instantiated for every NOR term.
REQ-039 The target implementation size is 120-400 lines of RTL.

Verification
REQ-040 Truth table: WIDTH=8, a=8'hF0, b=8'hCC, op 0..7 back-to-back, out_ready=1 -> y = 03, 0F, C0, FC, 3F, 3C, C3, F0 on consecutive cycles starting 2 cycles after the first beat.
REQ-041 Backpressure: stream 6 beats with out_ready toggling 1,0,0,1,... -> in-order delivery, no loss, y stable while stalled.
REQ-042 Accumulate: acc_clr, then beats {acc_mode=1, op=3, b=8'h01}, {acc_mode=1, op=5, b=8'h03} -> y = 01 then 02, with in_ready low while each beat is in flight.
REQ-043 Clear collision: acc_clr asserted in the same cycle as the handshake of y=8'hAA -> next acc_mode PASS-A beat yields 00 with y_zero=1.
REQ-044 Reset mid-stream: rst_n pulsed low with 2 beats in flight -> out_valid=0 and y=0 immediately, no output handshake, and a new beat completes normally after release.
REQ-045 Width sweep: WIDTH=1 and WIDTH=64 with random a/b/op over 1000 beats -> y matches the reference bitwise model.
